down_counter_sequencer: RTL and testbench

Control FSM and loadable down-counter datapath for programmable countdown timing.
- Loads a start value, runs the count down at a prescaled rate, and supports pause, resume and abort.
- Flags terminal count, with optional automatic reload.
- Sits between a host/register interface and the timing consumers. It is the sequencing layer on top of the team's synchronous down counters.

---
 rtl/down_counter_sequencer.sv | 149 ++++++++++++++
 tb/tb_down_counter_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_sequencer.sv
// ============================================================================
// Module   : down_counter_sequencer
// Purpose  : Sequencing FSM around a loadable, prescaled down-counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter_sequencer #(
  parameter int WIDTH = 3,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             paused,
  output logic             done,
  output logic             tc_pulse
);

  localparam int              c_PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_PW-1:0] c_DIV_M1 = c_PW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADED = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_count;
  logic [WIDTH-1:0]  w_count_nxt;
  logic [WIDTH-1:0]  r_reload;
  logic [WIDTH-1:0]  w_reload_nxt;
  logic [c_PW-1:0]   r_presc;
  logic [c_PW-1:0]   w_presc_nxt;
  logic              w_tick;
  logic              w_tc_nxt;
  logic              r_running;
  logic              r_paused;
  logic              r_done;
  logic              r_tc_pulse;

  assign w_tick = (r_presc == c_DIV_M1);

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_presc_nxt  = r_presc;
    w_tc_nxt     = 1'b0;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = r_reload;
      w_presc_nxt = '0;
    end else if (load) begin
      w_state_nxt  = S_LOADED;
      w_count_nxt  = load_val;
      w_reload_nxt = load_val;
      w_presc_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOADED: begin
          if (start) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = '0;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            w_presc_nxt = '0;
            if (r_count != '0) begin
              w_count_nxt = r_count - 1'b1;
            end else begin
              w_tc_nxt = 1'b1;
              if (auto_reload) begin
                w_count_nxt = r_reload;
              end else begin
                w_state_nxt = S_DONE;
              end
            end
          end else if (!pause) begin
            w_presc_nxt = r_presc + 1'b1;
          end
          // The tick still completes on a pause cycle; pause only takes effect if we stay in RUN.
          if (pause && (w_state_nxt == S_RUN)) begin
            w_state_nxt = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (start) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          if (start) begin
            w_state_nxt = S_RUN;
            w_count_nxt = r_reload;
            w_presc_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '1;
      r_reload   <= '1;
      r_presc    <= '0;
      r_running  <= 1'b0;
      r_paused   <= 1'b0;
      r_done     <= 1'b0;
      r_tc_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_reload   <= w_reload_nxt;
      r_presc    <= w_presc_nxt;
      r_running  <= (w_state_nxt == S_RUN);
      r_paused   <= (w_state_nxt == S_PAUSE);
      r_done     <= (w_state_nxt == S_DONE);
      r_tc_pulse <= w_tc_nxt;
    end
  end

  assign count    = r_count;
  assign running  = r_running;
  assign paused   = r_paused;
  assign done     = r_done;
  assign tc_pulse = r_tc_pulse;

endmodule

`default_nettype wire

// File: tb/tb_down_counter_sequencer.sv
// ============================================================================
// Module   : tb_down_counter_sequencer
// Purpose  : Self-checking bench; DIV=1 and DIV=4 instances share one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, start, pause, abort, auto_reload;
  logic [2:0] load_val;
  logic [2:0] c1, c4;
  logic       r1, p1, d1, t1;
  logic       r4, p4, d4, t4;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int IDLE = 0, LOADED = 1, RUN = 2, PAUSED = 3, FINISHED = 4;
  int m_st [2];
  int m_cnt[2];
  int m_rel[2];
  int m_pre[2];
  bit m_tc [2];

  always #5 clk = ~clk;

  down_counter_sequencer #(.WIDTH(3), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .abort(abort), .auto_reload(auto_reload),
    .count(c1), .running(r1), .paused(p1), .done(d1), .tc_pulse(t1)
  );

  down_counter_sequencer #(.WIDTH(3), .DIV(4)) u4 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .abort(abort), .auto_reload(auto_reload),
    .count(c4), .running(r4), .paused(p4), .done(d4), .tc_pulse(t4)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = IDLE; m_cnt[d] = 7; m_rel[d] = 7; m_pre[d] = 0; m_tc[d] = 0;
    end
  endtask

  // One clock of the countdown rules for instance d with divide ratio div.
  task automatic model_step(int d, int div);
    m_tc[d] = 0;
    if (abort) begin
      m_st[d] = IDLE; m_cnt[d] = m_rel[d]; m_pre[d] = 0;
    end else if (load) begin
      m_st[d] = LOADED; m_cnt[d] = int'(load_val); m_rel[d] = int'(load_val); m_pre[d] = 0;
    end else if ((m_st[d] == IDLE || m_st[d] == LOADED) && start) begin
      m_st[d] = RUN; m_pre[d] = 0;
    end else if (m_st[d] == RUN) begin
      if (m_pre[d] == div - 1) begin
        m_pre[d] = 0;
        if (m_cnt[d] > 0) m_cnt[d] = m_cnt[d] - 1;
        else begin
          m_tc[d] = 1;
          if (auto_reload) m_cnt[d] = m_rel[d];
          else m_st[d] = FINISHED;
        end
      end else if (!pause) begin
        m_pre[d] = m_pre[d] + 1;
      end
      if (pause && m_st[d] == RUN) m_st[d] = PAUSED;
    end else if (m_st[d] == PAUSED && start) begin
      m_st[d] = RUN;
    end else if (m_st[d] == FINISHED && start) begin
      m_st[d] = RUN; m_cnt[d] = m_rel[d]; m_pre[d] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      model_step(0, 1);
      model_step(1, 4);
    end
    #1;
  endtask

  task automatic idle_cmds();
    load = 0; start = 0; pause = 0; abort = 0; auto_reload = 0; load_val = 0;
  endtask

  task automatic do_reset();
    rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    idle_cmds();
    do_reset();
    n_checks++;
    if ({c1, r1, p1, d1, t1} !== 7'b111_0000) begin
      n_fail++; $display("FAIL reset_div1 got %b want 1110000", {c1, r1, p1, d1, t1});
    end
    n_checks++;
    if ({c4, r4, p4, d4, t4} !== 7'b111_0000) begin
      n_fail++; $display("FAIL reset_div4 got %b want 1110000", {c4, r4, p4, d4, t4});
    end
  endtask

  task automatic test_basic();
    int exp_c[4] = '{2, 1, 0, 0};
    do_reset();
    load = 1; load_val = 3; cycle(); load = 0;
    n_checks++;
    if (c1 !== 3'd3 || r1 !== 1'b0) begin
      n_fail++; $display("FAIL basic_load count=%0d run=%b want 3,0", c1, r1);
    end
    start = 1; cycle(); start = 0;
    n_checks++;
    if (c1 !== 3'd3 || r1 !== 1'b1) begin
      n_fail++; $display("FAIL basic_start count=%0d run=%b want 3,1", c1, r1);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (c1 !== 3'(exp_c[i]) || t1 !== (i == 3) || d1 !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_step%0d count=%0d tc=%b done=%b want %0d,%0d,%0d",
                 i, c1, t1, d1, exp_c[i], i == 3, i == 3);
      end
    end
    cycle();
    n_checks++;
    if (t1 !== 1'b0 || d1 !== 1'b1 || c1 !== 3'd0) begin
      n_fail++; $display("FAIL basic_hold tc=%b done=%b count=%0d want 0,1,0", t1, d1, c1);
    end
    start = 1; cycle(); start = 0;
    n_checks++;
    if (c1 !== 3'd3 || r1 !== 1'b1 || d1 !== 1'b0) begin
      n_fail++; $display("FAIL done_restart count=%0d run=%b done=%b want 3,1,0", c1, r1, d1);
    end
  endtask

  task automatic test_prescale();
    int n = 0;
    do_reset();
    load = 1; load_val = 2; cycle(); load = 0;
    start = 1; cycle(); start = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (t4 && n == 0) n = i;
      if (i == 3 || i == 4 || i == 8) begin
        n_checks++;
        if (c4 !== ((i == 3) ? 3'd2 : (i == 4) ? 3'd1 : 3'd0)) begin
          n_fail++; $display("FAIL prescale_edge%0d count=%0d", i, c4);
        end
      end
    end
    n_checks++;
    if (n != 12) begin
      n_fail++; $display("FAIL prescale_tc_latency got %0d want 12", n);
    end
  endtask

  task automatic test_auto_reload();
    do_reset();
    load = 1; load_val = 1; cycle(); load = 0;
    auto_reload = 1;
    start = 1; cycle(); start = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      n_checks++;
      if (c1 !== ((i % 2 == 1) ? 3'd0 : 3'd1) || t1 !== (i % 2 == 0) || d1 !== 1'b0 || r1 !== 1'b1) begin
        n_fail++;
        $display("FAIL autoreload_%0d count=%0d tc=%b done=%b run=%b want %0d,%0d,0,1",
                 i, c1, t1, d1, r1, (i % 2 == 1) ? 0 : 1, i % 2 == 0);
      end
    end
    auto_reload = 0;
  endtask

  task automatic test_pause();
    do_reset();
    load = 1; load_val = 5; cycle(); load = 0;
    start = 1; cycle(); start = 0;
    cycle(); cycle();
    pause = 1; cycle(); pause = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (c4 !== 3'd5 || p4 !== 1'b1 || r4 !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold%0d count=%0d paused=%b run=%b want 5,1,0", i, c4, p4, r4);
      end
    end
    start = 1; cycle(); start = 0;
    cycle();
    n_checks++;
    if (c4 !== 3'd5 || r4 !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume1 count=%0d run=%b want 5,1", c4, r4);
    end
    cycle();
    n_checks++;
    if (c4 !== 3'd4) begin
      n_fail++; $display("FAIL pause_resume2 count=%0d want 4", c4);
    end
  endtask

  task automatic test_abort_load();
    do_reset();
    load = 1; load_val = 6; cycle(); load = 0;
    start = 1; cycle(); start = 0;
    cycle(); cycle();
    abort = 1; load = 1; load_val = 2; cycle(); abort = 0; load = 0;
    n_checks++;
    if ({c1, r1, p1, d1, t1} !== 7'b110_0000) begin
      n_fail++; $display("FAIL abort_over_load got %b want 1100000", {c1, r1, p1, d1, t1});
    end
    load = 1; cycle(); load = 0;
    start = 1; pause = 1; cycle(); start = 0; pause = 0;
    n_checks++;
    if (r1 !== 1'b1 || p1 !== 1'b0 || c1 !== 3'd2) begin
      n_fail++; $display("FAIL start_over_pause run=%b paused=%b count=%0d want 1,0,2", r1, p1, c1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load = 1; load_val = 4; cycle(); load = 0;
    start = 1; cycle(); start = 0;
    cycle();
    #2 rst = 1; model_reset();
    #1;
    n_checks++;
    if ({c1, r1, p1, d1, t1} !== 7'b111_0000 || {c4, r4, p4, d4, t4} !== 7'b111_0000) begin
      n_fail++;
      $display("FAIL async_reset got %b / %b want 1110000", {c1, r1, p1, d1, t1}, {c4, r4, p4, d4, t4});
    end
    #1 rst = 0;
    cycle();
    n_checks++;
    if ({c1, r1, p1, d1, t1} !== 7'b111_0000) begin
      n_fail++; $display("FAIL async_release got %b want 1110000", {c1, r1, p1, d1, t1});
    end
  endtask

  task automatic test_random();
    logic [6:0] obs, exp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      abort    = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 4) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      load_val = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) auto_reload = ~auto_reload;
      cycle();
      for (int d = 0; d < 2; d++) begin
        obs = (d == 0) ? {c1, r1, p1, d1, t1} : {c4, r4, p4, d4, t4};
        exp = {3'(m_cnt[d]), m_st[d] == RUN, m_st[d] == PAUSED, m_st[d] == FINISHED, m_tc[d]};
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL random_c%0d_inst%0d got %b want %b", i, d, obs, exp);
        end
      end
    end
    idle_cmds();
  endtask

  initial begin
    rst = 1;
    idle_cmds();
    model_reset();
    test_reset();
    test_basic();
    test_prescale();
    test_auto_reload();
    test_pause();
    test_abort_load();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
